// File: rtl/mac_ctrl_seq.sv
// MAC-array control sequencer: weight-row loads, input-column loads,
// one calc strobe, latency drain, then a one-cycle DONE pulse.
module mac_ctrl_seq #(
    parameter int CALC_LAT = 12
) (
    input  logic       CLK,
    input  logic       RSTN,
    input  logic       START,
    input  logic       HOLD,
    input  logic [3:0] CFG_NROW,
    input  logic [3:0] CFG_NCOL,
    input  logic [4:0] CFG_SHAMT,
    input  logic [3:0] CFG_ODST,
    output logic       BUSY,
    output logic       DONE,
    output logic       START_CALC0,
    output logic       ILoad0,
    output logic       WLoad0,
    output logic [4:0] shamt0,
    output logic [3:0] ICOL0,
    output logic [3:0] WROW0,
    output logic [3:0] ODST0
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WLOAD,
        S_ILOAD,
        S_CALC,
        S_DRAIN,
        S_FIN
    } state_t;

    localparam logic [7:0] LAT_END = 8'(CALC_LAT);

    state_t     state, n_state;
    logic [3:0] row_cnt, n_row_cnt;
    logic [3:0] col_cnt, n_col_cnt;
    logic [7:0] lat_cnt, n_lat_cnt;
    logic [3:0] nrow, n_nrow;
    logic [3:0] ncol, n_ncol;
    logic [4:0] shamt, n_shamt;
    logic [3:0] odst, n_odst;

    logic       n_busy, n_done, n_calc, n_iload, n_wload;
    logic [4:0] n_shamt0;
    logic [3:0] n_icol, n_wrow, n_odst0;
    logic       stall;

    // HOLD only bites in the streaming/drain states; IDLE and FIN ignore it
    assign stall = HOLD && (state == S_WLOAD || state == S_ILOAD ||
                            state == S_CALC  || state == S_DRAIN);

    always_comb begin
        n_state   = state;
        n_row_cnt = row_cnt;
        n_col_cnt = col_cnt;
        n_lat_cnt = lat_cnt;
        n_nrow    = nrow;
        n_ncol    = ncol;
        n_shamt   = shamt;
        n_odst    = odst;
        n_done    = 1'b0;
        n_calc    = 1'b0;
        n_iload   = 1'b0;
        n_wload   = 1'b0;
        n_shamt0  = '0;
        n_odst0   = '0;
        n_icol    = '0;
        n_wrow    = '0;

        if (stall) begin
            n_icol = ICOL0;
            n_wrow = WROW0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (START) begin
                        n_nrow    = CFG_NROW;
                        n_ncol    = CFG_NCOL;
                        n_shamt   = CFG_SHAMT;
                        n_odst    = CFG_ODST;
                        n_row_cnt = '0;
                        n_col_cnt = '0;
                        n_state   = S_WLOAD;
                    end
                end
                S_WLOAD: begin
                    n_wload = 1'b1;
                    n_wrow  = row_cnt;
                    if (row_cnt == nrow) begin
                        n_state = S_ILOAD;
                    end else begin
                        n_row_cnt = row_cnt + 4'd1;
                    end
                end
                S_ILOAD: begin
                    n_iload = 1'b1;
                    n_icol  = col_cnt;
                    if (col_cnt == ncol) begin
                        n_state = S_CALC;
                    end else begin
                        n_col_cnt = col_cnt + 4'd1;
                    end
                end
                S_CALC: begin
                    n_calc    = 1'b1;
                    n_shamt0  = shamt;
                    n_odst0   = odst;
                    n_lat_cnt = '0;
                    n_state   = S_DRAIN;
                end
                S_DRAIN: begin
                    // DONE is registered on the way into FIN so it is seen with BUSY=1
                    if (lat_cnt == LAT_END) begin
                        n_done  = 1'b1;
                        n_state = S_FIN;
                    end else begin
                        n_lat_cnt = lat_cnt + 8'd1;
                    end
                end
                S_FIN: begin
                    n_state = S_IDLE;
                end
                default: begin
                    n_state = S_IDLE;
                end
            endcase
        end

        n_busy = (n_state != S_IDLE);
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state       <= S_IDLE;
            row_cnt     <= '0;
            col_cnt     <= '0;
            lat_cnt     <= '0;
            nrow        <= '0;
            ncol        <= '0;
            shamt       <= '0;
            odst        <= '0;
            BUSY        <= 1'b0;
            DONE        <= 1'b0;
            START_CALC0 <= 1'b0;
            ILoad0      <= 1'b0;
            WLoad0      <= 1'b0;
            shamt0      <= '0;
            ICOL0       <= '0;
            WROW0       <= '0;
            ODST0       <= '0;
        end else begin
            state       <= n_state;
            row_cnt     <= n_row_cnt;
            col_cnt     <= n_col_cnt;
            lat_cnt     <= n_lat_cnt;
            nrow        <= n_nrow;
            ncol        <= n_ncol;
            shamt       <= n_shamt;
            odst        <= n_odst;
            BUSY        <= n_busy;
            DONE        <= n_done;
            START_CALC0 <= n_calc;
            ILoad0      <= n_iload;
            WLoad0      <= n_wload;
            shamt0      <= n_shamt0;
            ICOL0       <= n_icol;
            WROW0       <= n_wrow;
            ODST0       <= n_odst0;
        end
    end

endmodule

// File: tb/tb_mac_ctrl_seq.sv
// Directed bench for mac_ctrl_seq: reset, basic job, HOLD, max dims,
// config isolation and back-to-back jobs.
module tb_mac_ctrl_seq;

    logic       clk = 1'b0;
    logic       rstn;
    logic       start;
    logic       hold;
    logic [3:0] cfg_nrow;
    logic [3:0] cfg_ncol;
    logic [4:0] cfg_shamt;
    logic [3:0] cfg_odst;
    logic       busy, done, start_calc0, iload0, wload0;
    logic [4:0] shamt0;
    logic [3:0] icol0, wrow0, odst0;

    int nvec = 0;
    int nerr = 0;

    // event monitor, sampled on the falling edge
    int cyc = 0;
    int wl_cnt, il_cnt, calc_cnt, done_cnt;
    int wl_exp, il_exp, seq_err, ovl, zviol;
    int first_wl, done_cyc;
    logic [4:0] calc_sh;
    logic [3:0] calc_od;
    logic       busy_at_done;

    mac_ctrl_seq #(.CALC_LAT(12)) dut (
        .CLK        (clk),
        .RSTN       (rstn),
        .START      (start),
        .HOLD       (hold),
        .CFG_NROW   (cfg_nrow),
        .CFG_NCOL   (cfg_ncol),
        .CFG_SHAMT  (cfg_shamt),
        .CFG_ODST   (cfg_odst),
        .BUSY       (busy),
        .DONE       (done),
        .START_CALC0(start_calc0),
        .ILoad0     (iload0),
        .WLoad0     (wload0),
        .shamt0     (shamt0),
        .ICOL0      (icol0),
        .WROW0      (wrow0),
        .ODST0      (odst0)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        cyc++;
        if (wload0) begin
            if (wl_cnt == 0) first_wl = cyc;
            if (int'(wrow0) != wl_exp) seq_err++;
            wl_exp++;
            wl_cnt++;
        end
        if (iload0) begin
            if (int'(icol0) != il_exp) seq_err++;
            il_exp++;
            il_cnt++;
        end
        if (start_calc0) begin
            calc_cnt++;
            calc_sh = shamt0;
            calc_od = odst0;
        end
        if (!start_calc0 && (shamt0 != 0 || odst0 != 0)) zviol++;
        if (int'(wload0) + int'(iload0) + int'(start_calc0) > 1) ovl++;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            busy_at_done = busy;
            wl_exp = 0;
            il_exp = 0;
        end
    end

    task automatic clr();
        wl_cnt = 0; il_cnt = 0; calc_cnt = 0; done_cnt = 0;
        wl_exp = 0; il_exp = 0; seq_err = 0; ovl = 0; zviol = 0;
        first_wl = 0; done_cyc = 0;
        calc_sh = '0; calc_od = '0; busy_at_done = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic start_job(input logic [3:0] nr, input logic [3:0] nc,
                             input logic [4:0] sh, input logic [3:0] od);
        cfg_nrow  = nr;
        cfg_ncol  = nc;
        cfg_shamt = sh;
        cfg_odst  = od;
        start     = 1'b1;
        step();
        start     = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            step();
            if (done === 1'b1) seen = 1'b1;
        end
        chk(tag, 32'(seen), 32'd1);
    endtask

    initial begin
        rstn = 1'b0; start = 1'b0; hold = 1'b0;
        cfg_nrow = '0; cfg_ncol = '0; cfg_shamt = '0; cfg_odst = '0;
        clr();
        step();
        step();
        chk("reset_outs", 32'({busy, done, start_calc0, iload0, wload0,
                              shamt0, icol0, wrow0, odst0}), 32'd0);
        rstn = 1'b1;
        step();

        // mid-WLOAD reset aborts without DONE
        clr();
        start_job(4'd5, 4'd1, 5'd3, 4'd4);
        step();
        step();
        chk("pre_rst_wload", 32'(wload0), 32'd1);
        rstn = 1'b0;
        step();
        step();
        chk("midrst_outs", 32'({busy, done, start_calc0, iload0, wload0,
                               shamt0, icol0, wrow0, odst0}), 32'd0);
        rstn = 1'b1;
        for (int i = 0; i < 25; i++) step();
        chk("midrst_nodone", 32'(done_cnt), 32'd0);
        chk("midrst_idle", 32'(busy), 32'd0);

        // basic job: first WLoad to DONE = 3+2+3+12 = 20 cycles
        clr();
        start_job(4'd3, 4'd2, 5'd5, 4'd9);
        chk("basic_busy", 32'(busy), 32'd1);
        chk("basic_nowl_yet", 32'(wload0), 32'd0);
        wait_done("basic_done", 60);
        @(negedge clk); #1;
        chk("basic_wl_cnt", 32'(wl_cnt), 32'd4);
        chk("basic_il_cnt", 32'(il_cnt), 32'd3);
        chk("basic_calc_cnt", 32'(calc_cnt), 32'd1);
        chk("basic_shamt", 32'(calc_sh), 32'd5);
        chk("basic_odst", 32'(calc_od), 32'd9);
        chk("basic_seq", 32'(seq_err), 32'd0);
        chk("basic_lat", 32'(done_cyc - first_wl), 32'd20);
        chk("basic_busy_done", 32'(busy_at_done), 32'd1);
        chk("basic_ovl", 32'(ovl), 32'd0);
        chk("basic_zero", 32'(zviol), 32'd0);
        step();
        chk("basic_done_pulse", 32'(done), 32'd0);
        chk("basic_idle", 32'(busy), 32'd0);

        // HOLD for 3 cycles while WROW0=2
        clr();
        start_job(4'd3, 4'd2, 5'd1, 4'd2);
        for (int i = 0; i < 10 && !(wload0 && wrow0 == 4'd2); i++) step();
        chk("hold_reach", 32'({wload0, wrow0}), 32'h12);
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hold_strobe", 32'(wload0), 32'd0);
            chk("hold_wrow", 32'(wrow0), 32'd2);
        end
        hold = 1'b0;
        step();
        chk("hold_resume", 32'({wload0, wrow0}), 32'h13);
        wait_done("hold_done", 60);
        @(negedge clk); #1;
        chk("hold_wl_cnt", 32'(wl_cnt), 32'd4);
        chk("hold_seq", 32'(seq_err), 32'd0);
        chk("hold_lat", 32'(done_cyc - first_wl), 32'd23);

        // maximum dimensions
        step();
        clr();
        start_job(4'd15, 4'd15, 5'd31, 4'd15);
        wait_done("max_done", 100);
        @(negedge clk); #1;
        chk("max_wl_cnt", 32'(wl_cnt), 32'd16);
        chk("max_il_cnt", 32'(il_cnt), 32'd16);
        chk("max_seq", 32'(seq_err), 32'd0);
        chk("max_lat", 32'(done_cyc - first_wl), 32'd45);
        chk("max_shamt", 32'(calc_sh), 32'd31);

        // START held and CFG changed while busy
        step();
        clr();
        start_job(4'd1, 4'd0, 5'd7, 4'd3);
        start     = 1'b1;
        cfg_nrow  = 4'd9;
        cfg_ncol  = 4'd8;
        cfg_shamt = 5'd20;
        cfg_odst  = 4'd12;
        wait_done("cfg_done", 60);
        start = 1'b0;
        @(negedge clk); #1;
        chk("cfg_wl_cnt", 32'(wl_cnt), 32'd2);
        chk("cfg_il_cnt", 32'(il_cnt), 32'd1);
        chk("cfg_shamt", 32'(calc_sh), 32'd7);
        chk("cfg_odst", 32'(calc_od), 32'd3);
        chk("cfg_one_done", 32'(done_cnt), 32'd1);

        // back-to-back jobs
        step();
        clr();
        start_job(4'd2, 4'd1, 5'd2, 4'd6);
        wait_done("b2b_done1", 60);
        step();
        chk("b2b_gap_idle", 32'(busy), 32'd0);
        start_job(4'd0, 4'd3, 5'd4, 4'd8);
        chk("b2b_busy2", 32'(busy), 32'd1);
        step();
        chk("b2b_first_wl2", 32'({wload0, wrow0}), 32'h10);
        wait_done("b2b_done2", 60);
        @(negedge clk); #1;
        chk("b2b_done_cnt", 32'(done_cnt), 32'd2);
        chk("b2b_calc_cnt", 32'(calc_cnt), 32'd2);
        chk("b2b_wl_cnt", 32'(wl_cnt), 32'd4);
        chk("b2b_il_cnt", 32'(il_cnt), 32'd6);
        chk("b2b_ovl", 32'(ovl), 32'd0);
        chk("b2b_seq", 32'(seq_err), 32'd0);
        chk("b2b_shamt2", 32'(calc_sh), 32'd4);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
